// File: rtl/drac_pkg.sv
// drac_pkg -- shared definitions for the DRAC timer/interrupt unit.
//   * register byte offsets of the timer block
//   * CTRL register field positions
//   * be_to_mask(): expands 8 byte enables into a 64-bit bit mask
package drac_pkg;

  localparam logic [4:0] TIMER_MTIME_OFF    = 5'h00;
  localparam logic [4:0] TIMER_MTIMECMP_OFF = 5'h08;
  localparam logic [4:0] TIMER_MSIP_OFF     = 5'h10;
  localparam logic [4:0] TIMER_CTRL_OFF     = 5'h18;

  // CTRL layout: bit 0 = EN, PRESCALE starts at bit 8.
  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;

  function automatic logic [63:0] be_to_mask(input logic [7:0] be);
    return {{8{be[7]}}, {8{be[6]}}, {8{be[5]}}, {8{be[4]}},
            {8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/drac_mtime_counter.sv
// drac_mtime_counter -- prescaler plus 64-bit MTIME counter.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   en_i               count enable (CTRL.EN)
//   prescale_i         tick divider: one MTIME increment every prescale_i+1 cycles
//   cnt_clr_i          restart the prescaler (CTRL written)
//   mtime_we_i         load mtime_wdata_i into MTIME; wins over a coincident tick
//   mtime_wdata_i      byte-merged value to load
//   mtime_o            current MTIME
module drac_mtime_counter #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  cnt_clr_i,
  input  logic                  mtime_we_i,
  input  logic [63:0]           mtime_wdata_i,
  output logic [63:0]           mtime_o
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [63:0]           mtime_q;
  logic                  tick;

  assign tick    = en_i && (cnt_q == prescale_i);
  assign mtime_o = mtime_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      mtime_q <= '0;
    end else begin
      // Counter is parked at 0 while disabled so re-enabling starts a full period.
      if (!en_i || cnt_clr_i || tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + PRESCALE_W'(1);
      end
      // A software write replaces the value and swallows the tick; the
      // increment wraps silently at 2^64.
      if (mtime_we_i) begin
        mtime_q <= mtime_wdata_i;
      end else if (tick) begin
        mtime_q <= mtime_q + 64'd1;
      end
    end
  end

endmodule

// File: rtl/drac_timer_irq_unit.sv
// drac_timer_irq_unit -- memory-mapped machine timer and interrupt combiner.
// Register map (byte offsets): 0x00 MTIME, 0x08 MTIMECMP, 0x10 MSIP (bit 0),
// 0x18 CTRL (bit 0 EN, PRESCALE at bit 8). Misaligned or out-of-range
// offsets answer with err=1, rdata=0 and change nothing.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   reg_req_*                register request channel (valid/ready)
//   reg_rsp_*                register response channel (valid/ready)
//   ext_irq_i                external interrupt level
//   time_o                   MTIME
//   time_irq_o               registered MTIME >= MTIMECMP
//   irq_o                    registered (conditioned ext_irq_i | MSIP)
// Build option: define DRAC_TIMER_EXT_IRQ_SYNC_EN to pass ext_irq_i through a
// 2-flop synchronizer (irq_o latency 3 cycles instead of 1).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Only one access is in flight: reg_req_ready_o is high exactly when no
// response is pending. The response appears the cycle after acceptance and
// valid/rdata/err hold until the edge where reg_rsp_ready_i is high.
module drac_timer_irq_unit
  import drac_pkg::*;
#(
  parameter int unsigned PRESCALE_W   = 8,
  parameter logic [63:0] RST_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        reg_req_valid_i,
  output logic        reg_req_ready_o,
  input  logic        reg_req_we_i,
  input  logic [4:0]  reg_req_addr_i,
  input  logic [63:0] reg_req_wdata_i,
  input  logic [7:0]  reg_req_be_i,
  output logic        reg_rsp_valid_o,
  input  logic        reg_rsp_ready_i,
  output logic [63:0] reg_rsp_rdata_o,
  output logic        reg_rsp_err_o,
  input  logic        ext_irq_i,
  output logic [63:0] time_o,
  output logic        time_irq_o,
  output logic        irq_o
);

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp_q;
  logic                  msip_q;
  logic                  en_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  rsp_valid_q;
  logic [63:0]           rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  time_irq_q;
  logic                  irq_q;
  logic                  ext_cond;

  logic                  req_fire;
  logic                  addr_ok;
  logic                  wr_ok;
  logic                  mtime_wr, mtimecmp_wr, msip_wr, ctrl_wr;
  logic [63:0]           wmask;
  logic [63:0]           rd_data;
  logic [63:0]           ctrl_rd;
  logic                  en_d;
  logic [PRESCALE_W-1:0] prescale_d;

  assign reg_req_ready_o = !rsp_valid_q;
  assign req_fire        = reg_req_valid_i && reg_req_ready_o;
  assign addr_ok         = (reg_req_addr_i[2:0] == 3'b000) && (reg_req_addr_i <= TIMER_CTRL_OFF);
  assign wr_ok           = req_fire && reg_req_we_i && addr_ok;
  assign mtime_wr        = wr_ok && (reg_req_addr_i == TIMER_MTIME_OFF);
  assign mtimecmp_wr     = wr_ok && (reg_req_addr_i == TIMER_MTIMECMP_OFF);
  assign msip_wr         = wr_ok && (reg_req_addr_i == TIMER_MSIP_OFF);
  assign ctrl_wr         = wr_ok && (reg_req_addr_i == TIMER_CTRL_OFF);
  assign wmask           = be_to_mask(reg_req_be_i);

  // CTRL fields are merged with the same byte mask as the 64-bit registers.
  assign en_d       = wmask[CTRL_EN_BIT] ? reg_req_wdata_i[CTRL_EN_BIT] : en_q;
  assign prescale_d = (prescale_q & ~wmask[CTRL_PRESCALE_LSB +: PRESCALE_W]) |
                      (reg_req_wdata_i[CTRL_PRESCALE_LSB +: PRESCALE_W] &
                       wmask[CTRL_PRESCALE_LSB +: PRESCALE_W]);

  always_comb begin
    ctrl_rd                                     = '0;
    ctrl_rd[CTRL_EN_BIT]                        = en_q;
    ctrl_rd[CTRL_PRESCALE_LSB +: PRESCALE_W]    = prescale_q;
  end

  always_comb begin
    rd_data = '0;
    case (reg_req_addr_i)
      TIMER_MTIME_OFF:    rd_data = mtime;
      TIMER_MTIMECMP_OFF: rd_data = mtimecmp_q;
      TIMER_MSIP_OFF:     rd_data = {63'd0, msip_q};
      TIMER_CTRL_OFF:     rd_data = ctrl_rd;
      default:            rd_data = '0;
    endcase
  end

  drac_mtime_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_mtime_counter (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_q),
    .prescale_i    (prescale_q),
    .cnt_clr_i     (ctrl_wr),
    .mtime_we_i    (mtime_wr),
    .mtime_wdata_i ((mtime & ~wmask) | (reg_req_wdata_i & wmask)),
    .mtime_o       (mtime)
  );

  // Writable registers other than MTIME.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtimecmp_q <= RST_MTIMECMP;
      msip_q     <= 1'b0;
      en_q       <= 1'b1;
      prescale_q <= '0;
    end else begin
      if (mtimecmp_wr) mtimecmp_q <= (mtimecmp_q & ~wmask) | (reg_req_wdata_i & wmask);
      if (msip_wr && reg_req_be_i[0]) msip_q <= reg_req_wdata_i[0];
      if (ctrl_wr) begin
        en_q       <= en_d;
        prescale_q <= prescale_d;
      end
    end
  end

  // Response channel: read data is captured in the acceptance cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (req_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= (addr_ok && !reg_req_we_i) ? rd_data : 64'd0;
      rsp_err_q   <= !addr_ok;
    end else if (rsp_valid_q && reg_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end
  end

`ifdef DRAC_TIMER_EXT_IRQ_SYNC_EN
  logic [1:0] ext_sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ext_sync_q <= 2'b00;
    end else begin
      ext_sync_q <= {ext_sync_q[0], ext_irq_i};
    end
  end

  assign ext_cond = ext_sync_q[1];
`else
  assign ext_cond = ext_irq_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      time_irq_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      time_irq_q <= (mtime >= mtimecmp_q);
      irq_q      <= ext_cond | msip_q;
    end
  end

  assign reg_rsp_valid_o = rsp_valid_q;
  assign reg_rsp_rdata_o = rsp_rdata_q;
  assign reg_rsp_err_o   = rsp_err_q;
  assign time_o          = mtime;
  assign time_irq_o      = time_irq_q;
  assign irq_o           = irq_q;

endmodule
